// File: rtl/kgp_alu_pkg.sv
// Shared ALU definitions: default datapath width and the divider FSM state type.
package kgp_alu_pkg;

    localparam int unsigned ALU_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_sub_stage.sv
// Combinational N-bit trial subtractor; borrow selects restore in the divider.
module div_sub_stage #(
    parameter int unsigned N = 33
) (
    input  logic [N-1:0] minuend,
    input  logic [N-1:0] subtrahend,
    output logic [N-1:0] diff_c,
    output logic         borrow_c
);

    always_comb begin
        {borrow_c, diff_c} = {1'b0, minuend} - {1'b0, subtrahend};
    end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock.
// Optional signed support with SEQ_DIV_SIGNED_EN (adds the is_signed port).
import kgp_alu_pkg::*;

module seq_divider #(
    parameter int unsigned W = ALU_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
`ifdef SEQ_DIV_SIGNED_EN
    input  logic         is_signed,
`endif
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam int unsigned CNT_W = $clog2(W + 1);

    div_state_t     state, state_nxt;
    logic [W:0]     rem_q;
    logic [W-1:0]   quo_q;
    logic [W-1:0]   dvsr_q;
    logic [CNT_W-1:0] cnt_q;

    logic [W:0]     trial_c;
    logic [W:0]     trial_diff_c;
    logic           trial_borrow_c;
    logic [W:0]     r_step_c;
    logic [W-1:0]   q_step_c;
    logic [W-1:0]   dvd_mag_c;
    logic [W-1:0]   dvs_mag_c;
    logic [W-1:0]   q_res_c;
    logic [W-1:0]   r_res_c;
    logic           divisor_zero_c;
    logic           accept_c;
    logic           last_step_c;

    // A successful trial leaves R below the divisor, so its top bit never feeds back.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[W];

    assign divisor_zero_c = (divisor == '0);
    assign accept_c       = (state == IDLE) && start;
    assign last_step_c    = (state == RUN) && (cnt_q == CNT_W'(W - 1));
    assign trial_c        = {rem_q[W-1:0], quo_q[W-1]};

    div_sub_stage #(.N(W + 1)) u_sub (
        .minuend    (trial_c),
        .subtrahend ({1'b0, dvsr_q}),
        .diff_c     (trial_diff_c),
        .borrow_c   (trial_borrow_c)
    );

    always_comb begin
        r_step_c = trial_borrow_c ? trial_c : trial_diff_c;
        q_step_c = {quo_q[W-2:0], ~trial_borrow_c};
    end

`ifdef SEQ_DIV_SIGNED_EN
    logic dvd_neg_c;
    logic dvs_neg_c;
    logic neg_q_q;
    logic neg_r_q;

    // Divide magnitudes, then fix signs so the result truncates toward zero.
    always_comb begin
        dvd_neg_c = is_signed & dividend[W-1];
        dvs_neg_c = is_signed & divisor[W-1];
        dvd_mag_c = dvd_neg_c ? -dividend : dividend;
        dvs_mag_c = dvs_neg_c ? -divisor : divisor;
        q_res_c   = neg_q_q ? -q_step_c : q_step_c;
        r_res_c   = neg_r_q ? -r_step_c[W-1:0] : r_step_c[W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
        end else if (accept_c) begin
            neg_q_q <= dvd_neg_c ^ dvs_neg_c;
            neg_r_q <= dvd_neg_c;
        end
    end
`else
    always_comb begin
        dvd_mag_c = dividend;
        dvs_mag_c = divisor;
        q_res_c   = q_step_c;
        r_res_c   = r_step_c[W-1:0];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = divisor_zero_c ? DONE : RUN;
                end
            end
            RUN: begin
                if (last_step_c) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Iteration registers: load on acceptance, one restoring step per RUN edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q  <= '0;
            quo_q  <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
        end else if (accept_c && !divisor_zero_c) begin
            rem_q  <= '0;
            quo_q  <= dvd_mag_c;
            dvsr_q <= dvs_mag_c;
            cnt_q  <= '0;
        end else if (state == RUN) begin
            rem_q  <= r_step_c;
            quo_q  <= q_step_c;
            cnt_q  <= cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_nxt != IDLE);
            done <= (state_nxt == DONE);
            if (accept_c && divisor_zero_c) begin
                quotient    <= '1;
                remainder   <= dividend;
                div_by_zero <= 1'b1;
            end else if (last_step_c) begin
                quotient    <= q_res_c;
                remainder   <= r_res_c;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative restoring divider for the ALU's multi-cycle path. It takes a dividend and divisor with a single-cycle start strobe, produces one quotient bit per clock using repeated trial subtraction, and returns quotient and remainder with a one-cycle done pulse. The block is the subtract-and-shift counterpart to the ALU's carry-lookahead add path, and it sits beside that path under the execute-stage controller.

## Interface
- `W`, default 32: operand, quotient and remainder width.
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  request strobe; accepted only in IDLE
- `dividend`  in  W  sampled on the accepting edge
- `divisor`  in  W  sampled on the accepting edge
- `is_signed`  in  1  present only with `SEQ_DIV_SIGNED_EN`; sampled with operands
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle pulse; results valid
- `quotient`  out  W  registered result, held until the next completion
- `remainder`  out  W  registered result, held until the next completion
- `div_by_zero`  out  1  registered flag, updated with each completion

## Operation
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values:
  - state = IDLE.
  - All outputs 0.
  - Internal accumulator and counter 0.
- States:
  - IDLE → RUN: on `start` with divisor ≠ 0.
  - IDLE → DONE: on `start` with divisor = 0.
  - RUN → DONE: after W step edges.
  - DONE → IDLE: unconditional.
- Registers:
  - Partial remainder R, W+1 bits.
  - Shifting dividend/quotient register Q, W bits.
  - Step counter, $clog2(W+1) bits.
- RUN step, per edge:
  - Compute T = {R[W-1:0], Q[W-1]} − {1'b0, divisor}.
  - If T is non-negative, meaning no borrow: R ← T and Q ← {Q[W-2:0], 1}.
  - Otherwise: R ← {R[W-1:0], Q[W-1]} and Q ← {Q[W-2:0], 0}.
- Entering DONE:
  - `quotient` ← Q and `remainder` ← R[W-1:0].
  - `div_by_zero` ← 0.
- Divide by zero:
  - `quotient` ← all ones, `remainder` ← dividend, `div_by_zero` ← 1.
  - No RUN cycles are spent.
- Ignored inputs:
  - `start` while `busy` is ignored.
  - Operand changes after the accepting edge have no effect.
- `done` is high exactly in the DONE state.
- Back-to-back operation: a `start` seen in the cycle DONE→IDLE occurs is ignored. It must be re-presented in IDLE.

## Timing
- Accepting edge E0 (IDLE, `start`=1):
  - `busy` rises after E0.
  - `done` is high in the cycle after edge E0+W, giving W+1 edges of latency.
  - `busy` falls one edge later.
- Divide by zero: `done` is high in the cycle after E0, giving 1 edge of latency.
- Throughput: one division per W+2 cycles, because one IDLE cycle is required between operations.
- Reset asserted mid-RUN or in DONE:
  - Immediate return to IDLE.
  - All outputs cleared.
  - No `done` pulse for the aborted operation.

## Configuration
- `SEQ_DIV_SIGNED_EN` defined:
  - The `is_signed` port exists.
  - When `is_signed`=1, operands are converted to magnitudes on acceptance and the signs are latched.
  - On entry to DONE, the quotient is negated if the signs differ, and the remainder is negated if the dividend was negative. This truncates toward zero.
  - Most-negative ÷ −1 yields quotient = most-negative and remainder 0.
  - Divide by zero gives the same result as the unsigned case, with the raw dividend returned.
  - Latency is unchanged.
- Undefined:
  - The port is absent and the block is unsigned only.
  - No negation logic is present.

## Structure
- Shared package `kgp_alu_pkg`:
  - `div_state_t` enum (IDLE, RUN, DONE).
  - Default width constant `ALU_W` = 32.
- One sub-module, `div_sub_stage`:
  - Combinational W+1-bit trial subtractor.
  - Outputs the difference and a borrow, used as the restore select.
- Counter, FSM, and sign handling stay in `seq_divider`.

## Test plan
- Basic unsigned (W=32): 100 ÷ 7 at E0 → `done` after 33 edges with `quotient`=14, `remainder`=2, `div_by_zero`=0. `busy` is high for 33 cycles.
- Edge values: 0xFFFFFFFF ÷ 1 → q=0xFFFFFFFF, r=0. Then 3 ÷ 10 → q=0, r=3.
- Divide by zero: 5 ÷ 0 → `done` after 1 edge with q=0xFFFFFFFF, r=5, `div_by_zero`=1. The flag clears on the next normal completion.
- Protocol:
  - `start` pulsed with 9 ÷ 3 at cycle 10 of a RUN → ignored, and the original result is unchanged.
  - `start` held high through DONE→IDLE → a second operation is accepted only in IDLE.
- Reset mid-RUN: deassert `rst_n` at cycle 15 → all outputs 0 and state IDLE immediately, with no `done` pulse. A fresh 100 ÷ 7 completes correctly afterward.
- Signed (macro defined, `is_signed`=1):
  - −7 ÷ 2 → q=0xFFFFFFFD, r=0xFFFFFFFF.
  - 0x80000000 ÷ 0xFFFFFFFF → q=0x80000000, r=0.
